// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer type and Gray/binary conversion.
// Functions work on 32 bits; callers zero-extend and truncate.
package fifo_pkg;

    localparam int ADDR_SIZE = 4;
    localparam int DEPTH     = 1 << ADDR_SIZE;

    typedef logic [ADDR_SIZE:0] ptr_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// N-flop synchroniser for a Gray-coded bus crossing into clk.
// Async active-low reset clears every stage to zero.
module sync_nff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    // shift the incoming bus through STAGES flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty/almost-empty, level and sticky underflow.
// Flags are computed from the post-pop pointer at the committing edge.
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE      = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int AEMPTY_DEFAULT = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rstn,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   wr_ptr_gray,
    input  logic [ADDR_SIZE:0]   rd_aempty_thresh,
    input  logic                 rd_underflow_clr,
    output logic                 rd_fire,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr_gray,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 rd_underflow
);

    localparam int PW = ADDR_SIZE + 1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (AEMPTY_DEFAULT > (1 << ADDR_SIZE)) begin : g_bad_ae
        $error("AEMPTY_DEFAULT exceeds FIFO depth");
    end

    logic [PW-1:0] wgray_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] level_next;

    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wsync (
        .clk   (rd_clk),
        .rst_n (rd_rstn),
        .d     (wr_ptr_gray),
        .q     (wgray_s)
    );

    // next pointer and post-pop occupancy
    always_comb begin
        rd_fire    = rd_en & ~rempty;
        wbin_s     = PW'(gray2bin(32'(wgray_s)));
        rbin_next  = rptr_bin + PW'(rd_fire);
        rgray_next = PW'(bin2gray(32'(rbin_next)));
        level_next = wbin_s - rbin_next;
    end

    // commit pointers and registered status
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
            raempty   <= 1'b1;
            rd_level  <= '0;
        end else begin
            rptr_bin  <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == wgray_s);
            raempty   <= (level_next <= rd_aempty_thresh);
            rd_level  <= level_next;
        end
    end

    // sticky underflow; a new set beats a clear
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_underflow <= 1'b0;
        end else if (rd_en && rempty) begin
            rd_underflow <= 1'b1;
        end else if (rd_underflow_clr) begin
            rd_underflow <= 1'b0;
        end
    end

    assign raddr = rptr_bin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Self-checking bench for rptr_empty_lvl against a count-based model.
// Model tracks written/popped counts and a write-count delay queue.
module tb_rptr_empty_lvl;

    localparam int AW = 4;
    localparam int S  = 2;
    localparam int PW = AW + 1;

    logic          rd_clk = 1'b0;
    logic          rd_rstn = 1'b0;
    logic          rd_en = 1'b0;
    logic [PW-1:0] wr_ptr_gray = '0;
    logic [PW-1:0] rd_aempty_thresh = PW'(2);
    logic          rd_underflow_clr = 1'b0;
    logic          rd_fire;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr_gray;
    logic          rempty;
    logic          raempty;
    logic [PW-1:0] rd_level;
    logic          rd_underflow;

    rptr_empty_lvl #(
        .ADDR_SIZE      (AW),
        .SYNC_STAGES    (S),
        .AEMPTY_DEFAULT (2)
    ) dut (
        .rd_clk           (rd_clk),
        .rd_rstn          (rd_rstn),
        .rd_en            (rd_en),
        .wr_ptr_gray      (wr_ptr_gray),
        .rd_aempty_thresh (rd_aempty_thresh),
        .rd_underflow_clr (rd_underflow_clr),
        .rd_fire          (rd_fire),
        .raddr            (raddr),
        .rptr_gray        (rptr_gray),
        .rempty           (rempty),
        .raempty          (raempty),
        .rd_level         (rd_level),
        .rd_underflow     (rd_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    int wcount;
    int rcount;
    int m_lvl;
    bit m_empty;
    bit m_aempty;
    bit m_uf;
    int wq[$];
    int checks;
    int errors;
    logic [PW-1:0] prev_g;

    function automatic logic [PW-1:0] g(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int mod32(input int v);
        return ((v % 32) + 32) % 32;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rcount   = 0;
        m_lvl    = 0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_uf     = 1'b0;
        wq       = {};
        for (int i = 0; i < S; i++) wq.push_back(0);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".level"}, int'(rd_level), m_lvl);
        chk({tag, ".empty"}, int'(rempty), int'(m_empty));
        chk({tag, ".aempty"}, int'(raempty), int'(m_aempty));
        chk({tag, ".uflow"}, int'(rd_underflow), int'(m_uf));
        chk({tag, ".raddr"}, int'(raddr), rcount % 16);
        chk({tag, ".rgray"}, int'(rptr_gray), int'(g(rcount)));
    endtask

    task automatic step(input bit en, input bit clr, input string tag);
        bit fire;
        int ham;
        rd_en = en;
        rd_underflow_clr = clr;
        wr_ptr_gray = g(wcount);
        #1;
        fire = en && !m_empty;
        chk({tag, ".fire"}, int'(rd_fire), int'(fire));
        @(posedge rd_clk);
        if (en && m_empty) m_uf = 1'b1;
        else if (clr) m_uf = 1'b0;
        rcount += int'(fire);
        m_lvl = mod32(wq[0] - rcount);
        m_empty = (m_lvl == 0);
        m_aempty = (m_lvl <= int'(rd_aempty_thresh));
        void'(wq.pop_front());
        wq.push_back(wcount);
        #1;
        chk_state(tag);
        ham = $countones(rptr_gray ^ prev_g);
        checks++;
        assert (ham <= 1) else begin
            errors++;
            $error("FAIL %s.hamming observed=%0d expected<=1", tag, ham);
        end
        prev_g = rptr_gray;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wcount = 0;
        prev_g = '0;
        model_reset();

        // 1: reset
        repeat (2) @(posedge rd_clk);
        #1;
        chk_state("rst");
        rd_rstn = 1'b1;

        // 2: five words arrive, pop three
        wcount = 5;
        repeat (S + 1) step(1'b0, 1'b0, "fill5");
        chk("fill5.lvl5", int'(rd_level), 5);
        repeat (3) step(1'b1, 1'b0, "pop3");
        chk("pop3.ae", int'(raempty), 1);

        // 3: drain, underflow, clear behaviour
        repeat (2) step(1'b1, 1'b0, "drain");
        chk("drain.empty", int'(rempty), 1);
        step(1'b1, 1'b0, "uf_set");
        chk("uf_set.flag", int'(rd_underflow), 1);
        step(1'b1, 1'b1, "uf_setwins");
        step(1'b0, 1'b1, "uf_clr");
        chk("uf_clr.flag", int'(rd_underflow), 0);

        // 4: stream 20 words through the wrap point
        for (int i = 0; i < 80 && rcount < 25; i++) begin
            if (wcount < 25 && wcount - rcount < 16) wcount++;
            step(1'b1, 1'b0, "wrap");
        end
        repeat (S + 1) step(1'b0, 1'b0, "wrap_idle");
        chk("wrap.rcount", rcount, 25);
        chk("wrap.empty", int'(rempty), 1);

        // 5: full FIFO, then one pop
        wcount = rcount + 16;
        repeat (S + 1) step(1'b0, 1'b0, "full");
        chk("full.lvl16", int'(rd_level), 16);
        chk("full.ae", int'(raempty), 0);
        step(1'b1, 1'b0, "full_pop");
        chk("full_pop.lvl15", int'(rd_level), 15);

        // random traffic with a different threshold
        rd_aempty_thresh = PW'(3);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1, 0) == 1 && wcount - rcount < 16)
                wcount++;
            step(1'($urandom_range(1, 0)),
                 1'($urandom_range(7, 0) == 0), "rand");
        end
        rd_underflow_clr = 1'b0;
        rd_aempty_thresh = PW'(2);

        // 6: async reset at level 7
        repeat (20) begin
            if (rcount < wcount) step(1'b1, 1'b0, "pre6");
        end
        wcount = rcount + 7;
        repeat (S + 1) step(1'b0, 1'b0, "lvl7");
        chk("lvl7.level", int'(rd_level), 7);
        #2;
        rd_rstn = 1'b0;
        #1;
        model_reset();
        wcount = 0;
        wr_ptr_gray = '0;
        chk_state("async_rst");
        @(posedge rd_clk);
        #1;
        rd_rstn = 1'b1;
        prev_g = '0;
        wcount = 3;
        repeat (6) step(1'b1, 1'b0, "post_rst");
        chk("post_rst.uf", int'(rd_underflow), 1);
        chk("post_rst.rcount", int'(raddr), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
